// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;
    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 3;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_num_t;
    typedef logic [DEFAULT_DATA_W-1:0] data_word_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits, reserve stall and busy counter for regfile_mp.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reservenum,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              reserve_stall,
    output logic [ADDR_W:0]   busy_count
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             inc;
    logic             dec;

    // Handshake: reserve is a request held by the decoder; it is accepted on
    // any edge where reserve_stall is low, otherwise it must stay asserted.
    assign reserve_stall = reserve & busy_q[reservenum];
    assign inc           = reserve & ~reserve_stall;
    assign dec           = write & busy_q[writenum];

    assign busy_a = busy_q[readnum_a];
    assign busy_b = busy_q[readnum_b];

    // The reserve is applied after the write clear so it wins on a shared register.
    always_comb begin
        busy_d = busy_q;
        if (write) busy_d[writenum] = 1'b0;
        if (inc)   busy_d[reservenum] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            busy_count <= '0;
        end else begin
            busy_q <= busy_d;
            if (inc && !dec)
                busy_count <= busy_count + 1'b1;
            else if (dec && !inc)
                busy_count <= busy_count - 1'b1;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Register file with one write port, two read ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reservenum,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              reserve_stall,
    output logic [ADDR_W:0]   busy_count
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              sb_busy_a;
    logic              sb_busy_b;
    logic              byp_a;
    logic              byp_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (write) begin
            mem[writenum] <= data_in;
        end
    end

    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .writenum     (writenum),
        .reserve      (reserve),
        .reservenum   (reservenum),
        .readnum_a    (readnum_a),
        .readnum_b    (readnum_b),
        .busy_a       (sb_busy_a),
        .busy_b       (sb_busy_b),
        .reserve_stall(reserve_stall),
        .busy_count   (busy_count)
    );

`ifdef REGFILE_BYPASS_EN
    assign byp_a = write & ~reset & (writenum == readnum_a);
    assign byp_b = write & ~reset & (writenum == readnum_b);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign data_out_a = byp_a ? data_in : mem[readnum_a];
    assign data_out_b = byp_b ? data_in : mem[readnum_b];
    assign busy_a     = sb_busy_a & ~byp_a;
    assign busy_b     = sb_busy_b & ~byp_b;
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int EW    = 2*DW + 3 + AW + 1;

    logic          clk;
    logic          reset;
    data_word_t    data_in;
    logic          write;
    reg_num_t      writenum;
    reg_num_t      readnum_a;
    reg_num_t      readnum_b;
    logic          reserve;
    reg_num_t      reservenum;
    logic [DW-1:0] data_out_a;
    logic [DW-1:0] data_out_b;
    logic          busy_a;
    logic          busy_b;
    logic          reserve_stall;
    logic [AW:0]   busy_count;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .write(write),
        .writenum(writenum), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .reserve(reserve), .reservenum(reservenum), .data_out_a(data_out_a),
        .data_out_b(data_out_b), .busy_a(busy_a), .busy_b(busy_b),
        .reserve_stall(reserve_stall), .busy_count(busy_count)
    );

    // clock/reset block: negedges fall between driver updates and posedges
    initial clk = 1'b1;
    always #5 clk = ~clk;

    // reference model: architectural state as plain arrays
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy [DEPTH];
    logic [EW-1:0] exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [EW-1:0] model_outputs();
        logic [DW-1:0] da, db;
        logic          ba, bb, st;
        logic [AW:0]   cnt;
        da  = m_mem[readnum_a];
        db  = m_mem[readnum_b];
        ba  = m_busy[readnum_a];
        bb  = m_busy[readnum_b];
`ifdef REGFILE_BYPASS_EN
        if (write && !reset && writenum == readnum_a) begin da = data_in; ba = 1'b0; end
        if (write && !reset && writenum == readnum_b) begin db = data_in; bb = 1'b0; end
`endif
        st  = reserve && m_busy[reservenum];
        cnt = (AW+1)'(model_count());
        return {da, db, ba, bb, st, cnt};
    endfunction

    // driver task: one cycle of stimulus, expected response queued before the edge
    task automatic drive(input bit rst, input bit wr, input int wn, input logic [DW-1:0] din,
                         input int ra, input int rb, input bit rs, input int rsn, input bit chk);
        bit stalled;
        reset      = rst;
        write      = wr;
        writenum   = reg_num_t'(wn);
        data_in    = din;
        readnum_a  = reg_num_t'(ra);
        readnum_b  = reg_num_t'(rb);
        reserve    = rs;
        reservenum = reg_num_t'(rsn);
        if (chk) exp_q.push_back(model_outputs());
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
        end else begin
            stalled = rs && m_busy[rsn];
            if (wr) begin m_mem[wn] = din; m_busy[wn] = 1'b0; end
            if (rs && !stalled) m_busy[rsn] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_read(input int ra, input int rb);
        drive(0, 0, 0, '0, ra, rb, 0, 0, 1);
    endtask

    // scoreboard monitor: compares whenever an expectation is pending
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e, a;
            e = exp_q.pop_front();
            a = {data_out_a, data_out_b, busy_a, busy_b, reserve_stall, busy_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle%0d outputs {da,db,ba,bb,stall,cnt} actual=%h required=%h",
                         cyc, a, e);
            end
            cyc++;
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
        // first reset with a write that must be ignored
        drive(1, 1, 1, 16'hDEAD, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 16'hBEEF, 1, 1, 1, 1, 1);
        for (int i = 0; i < DEPTH; i++) idle_read(i, DEPTH-1-i);

        // write R3, same-cycle read then next-cycle read
        drive(0, 1, 3, 16'h00A5, 3, 3, 0, 0, 1);
        idle_read(3, 3);

        // reserve R2, R5, then R2 again (stalls)
        drive(0, 0, 0, '0, 2, 5, 1, 2, 1);
        drive(0, 0, 0, '0, 2, 5, 1, 5, 1);
        drive(0, 0, 0, '0, 2, 5, 1, 2, 1);
        idle_read(2, 5);

        // write R2 while reserving R6
        drive(0, 1, 2, 16'h1234, 2, 6, 1, 6, 1);
        idle_read(2, 6);

        // reserve + write same register: not busy (R4), then busy (R5)
        drive(0, 1, 4, 16'h4444, 4, 5, 1, 4, 1);
        idle_read(4, 4);
        drive(0, 1, 5, 16'h5555, 5, 4, 1, 5, 1);
        idle_read(5, 5);
        drive(0, 0, 0, '0, 5, 4, 1, 5, 1);

        // fill every register, then reset mid-stream with a write pending
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, '0, i, 0, 1, i, 1);
        idle_read(0, 7);
        drive(1, 1, 3, 16'hFFFF, 3, 4, 1, 1, 1);
        idle_read(3, 4);

        // random phase
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH-1),
                  DW'($urandom), $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
                  $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH-1), 1);
        end

        drive(0, 0, 0, '0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the datapath: DEPTH = 2**ADDR_W registers of DATA_W bits.
- One write port and two independent combinational read ports (A, B).
- Per-register busy scoreboard: a register is reserved when a multi-cycle producer issues and released when its result is written back.
- Sits between the instruction decoder (read/reserve numbers) and the ALU/writeback stage.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register-number width; DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  write data.
- write  in  1  write enable.
- writenum  in  ADDR_W  write register number.
- readnum_a  in  ADDR_W  read port A register number.
- readnum_b  in  ADDR_W  read port B register number.
- reserve  in  1  request to mark reservenum busy.
- reservenum  in  ADDR_W  register number to reserve.
- data_out_a  out  DATA_W  contents of register readnum_a.
- data_out_b  out  DATA_W  contents of register readnum_b.
- busy_a  out  1  busy bit of readnum_a.
- busy_b  out  1  busy bit of readnum_b.
- reserve_stall  out  1  reserve refused this cycle.
- busy_count  out  ADDR_W+1  number of busy registers.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on port reset.
- Reset: at a clk edge with reset=1, all registers go to 0, all busy bits to 0, and busy_count to 0. write and reserve are ignored in that cycle. Reset asserted mid-operation discards all pending reservations.
- Write: at a clk edge with write=1 and reset=0, R[writenum] <= data_in and busy[writenum] <= 0. Write latency is one edge.
- Read: data_out_x = R[readnum_x] and busy_x = busy[readnum_x], both combinational from registered state. Both ports may address the same register. A read port may address writenum in the same cycle; see Optional Feature.
- reserve_stall = reserve & busy[reservenum], combinational from registered busy bits.
- Reserve: at an edge with reserve=1, reserve_stall=0 and reset=0, busy[reservenum] <= 1. A stalled reserve has no effect; the requester must hold the request.
- Reserve and write to the same register in the same cycle:
  - Register not busy: the reserve is accepted, so busy ends at 1. The reserve takes priority over the write's clear. The data is still written.
  - Register already busy: the reserve stalls and the write clears busy, so busy ends at 0. The requester retries and is accepted next cycle.
- busy_count update per edge, where inc = reserve accepted and dec = write to a currently busy register:
  - inc only: +1.
  - dec only: −1.
  - inc and dec on different registers: unchanged.
  - inc and dec on the same register: unchanged.
- busy_count never wraps. Its maximum is DEPTH and its minimum is 0.
- A write to a non-busy register is legal. It updates data and leaves busy_count unchanged.

Optional Feature:
- REGFILE_BYPASS_EN defined: when write=1 and writenum==readnum_x, data_out_x = data_in and busy_x = 0 combinationally, giving write-through in the same cycle. This is evaluated per port and is inactive while reset=1.
- REGFILE_BYPASS_EN undefined: reads return the pre-edge register value and busy bit. The new value is visible from the following cycle.

Decomposition:
- Package regfile_pkg:
  - default DATA_W/ADDR_W constants;
  - a typedef for register number;
  - a typedef for the data word.
- Sub-module regfile_scoreboard (busy bits, reserve_stall, busy_count), instantiated once. The storage array and read muxes stay in regfile_mp.

Test Plan:
- Reset then read all 8 registers on both ports -> data_out_a = data_out_b = 16'h0000; busy_a = busy_b = 0; busy_count = 0.
- Write 16'h00A5 to R3, next cycle readnum_a = readnum_b = 3 -> both ports 16'h00A5. Without bypass, the same-cycle read shows 16'h0000; with REGFILE_BYPASS_EN it shows 16'h00A5.
- Reserve R2, R5 on consecutive cycles -> busy_count = 2, busy for R2 = 1. Reserve R2 again -> reserve_stall = 1, busy_count stays 2.
- Write R2 = 16'h1234 while reserving R6 -> busy[R2] = 0, busy[R6] = 1, busy_count stays 2.
- R4 not busy: reserve R4 and write R4 in the same cycle -> R4 = data_in, busy[R4] = 1, busy_count +1. R5 busy: reserve R5 and write R5 -> reserve_stall = 1, busy[R5] = 0, busy_count −1.
- Reserve all 8 registers -> busy_count = 8, no wrap. Assert reset for one cycle mid-stream -> all registers 0, busy_count = 0, and the write in that cycle is ignored.
